// File: rtl/switch_allocator.sv
// rtl/switch_allocator.sv - wormhole switch allocator with per-port round-robin queued grants
// Optional macro SWITCH_ALLOC_STATS_EN adds per-port contention_cnt saturating counters.
module switch_allocator #(
    parameter int NUM_BUFFERS  = 4,
    parameter int NUM_OUTPORTS = 4,
    localparam int SELECT_SIZE  = $clog2(NUM_BUFFERS) + (NUM_BUFFERS == 1),
    localparam int REQUEST_SIZE = $clog2(NUM_OUTPORTS) + (NUM_OUTPORTS == 1)
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [NUM_BUFFERS-1:0]                      valid,
    input  logic                                        allocate,
    input  logic [SELECT_SIZE-1:0]                      requestor,
    input  logic [REQUEST_SIZE-1:0]                     requested,
    output logic [SELECT_SIZE-1:0]                      switch_valid,
    output logic [NUM_OUTPORTS-1:0][SELECT_SIZE-1:0]    select,
    output logic [NUM_OUTPORTS-1:0]                     enable,
    output logic [NUM_BUFFERS-1:0]                      grant
`ifdef SWITCH_ALLOC_STATS_EN
    ,
    output logic [NUM_OUTPORTS-1:0][15:0]               contention_cnt
`endif
);

    localparam logic [SELECT_SIZE:0]  BUF_LIMIT  = (SELECT_SIZE+1)'(NUM_BUFFERS);
    localparam logic [REQUEST_SIZE:0] PORT_LIMIT = (REQUEST_SIZE+1)'(NUM_OUTPORTS);

    logic [NUM_BUFFERS-1:0]                     pending;
    logic [NUM_BUFFERS-1:0][REQUEST_SIZE-1:0]   pend_port;
    logic [NUM_OUTPORTS-1:0][SELECT_SIZE-1:0]   rr_ptr;

    logic                                       req_in_range;
    logic                                       req_live;
    logic                                       new_ok;
    logic                                       req_overwrite;
    logic [NUM_BUFFERS-1:0]                     live_pending;
    logic [NUM_OUTPORTS-1:0]                    releasing;
    logic [NUM_OUTPORTS-1:0][NUM_BUFFERS-1:0]   cand;
    logic [NUM_OUTPORTS-1:0]                    port_win;
    logic [NUM_OUTPORTS-1:0][SELECT_SIZE-1:0]   winner;
    logic [NUM_BUFFERS-1:0]                     grant_next;
    logic                                       new_won;

    assign req_in_range  = ({1'b0, requestor} < BUF_LIMIT) && ({1'b0, requested} < PORT_LIMIT);
    assign req_live      = allocate && req_in_range && valid[requestor];
    assign new_ok        = req_live && !pending[requestor];
    assign req_overwrite = req_live && pending[requestor];

    // A buffer re-requesting while queued only retargets its entry; it cannot win this cycle.
    always_comb begin
        live_pending = pending & valid;
        for (int b = 0; b < NUM_BUFFERS; b++) begin
            if (req_overwrite && requestor == SELECT_SIZE'(b))
                live_pending[b] = 1'b0;
        end
    end

    always_comb begin
        releasing = '0;
        for (int o = 0; o < NUM_OUTPORTS; o++)
            releasing[o] = enable[o] && !valid[select[o]];
    end

    always_comb begin
        cand = '0;
        for (int o = 0; o < NUM_OUTPORTS; o++) begin
            for (int b = 0; b < NUM_BUFFERS; b++) begin
                if (live_pending[b] && pend_port[b] == REQUEST_SIZE'(o))
                    cand[o][b] = 1'b1;
                if (new_ok && requested == REQUEST_SIZE'(o) && requestor == SELECT_SIZE'(b))
                    cand[o][b] = 1'b1;
            end
        end
    end

    // Scan from the far end back toward rr_ptr so the last hit is the first candidate at/after it.
    always_comb begin
        port_win = '0;
        winner   = '0;
        for (int o = 0; o < NUM_OUTPORTS; o++) begin
            if (!enable[o]) begin
                for (int k = NUM_BUFFERS - 1; k >= 0; k--) begin
                    if (cand[o][(int'(rr_ptr[o]) + k) % NUM_BUFFERS]) begin
                        port_win[o] = 1'b1;
                        winner[o]   = SELECT_SIZE'((int'(rr_ptr[o]) + k) % NUM_BUFFERS);
                    end
                end
            end
        end
    end

    always_comb begin
        grant_next = '0;
        new_won    = 1'b0;
        for (int o = 0; o < NUM_OUTPORTS; o++) begin
            for (int b = 0; b < NUM_BUFFERS; b++) begin
                if (port_win[o] && winner[o] == SELECT_SIZE'(b))
                    grant_next[b] = 1'b1;
            end
            if (new_ok && port_win[o] && winner[o] == requestor && requested == REQUEST_SIZE'(o))
                new_won = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            switch_valid <= '0;
            select       <= '0;
            enable       <= '0;
            grant        <= '0;
            pending      <= '0;
            pend_port    <= '0;
            rr_ptr       <= '0;
        end else begin
            grant        <= grant_next;
            switch_valid <= SELECT_SIZE'(new_won);
            for (int o = 0; o < NUM_OUTPORTS; o++) begin
                if (releasing[o]) begin
                    enable[o] <= 1'b0;
                end else if (port_win[o]) begin
                    enable[o] <= 1'b1;
                    select[o] <= winner[o];
                    rr_ptr[o] <= (int'(winner[o]) == NUM_BUFFERS - 1) ? '0 : winner[o] + 1'b1;
                end
            end
            for (int b = 0; b < NUM_BUFFERS; b++) begin
                if (grant_next[b] || !valid[b]) begin
                    pending[b] <= 1'b0;
                end else if (req_live && requestor == SELECT_SIZE'(b)) begin
                    pending[b]   <= 1'b1;
                    pend_port[b] <= requested;
                end
            end
        end
    end

`ifdef SWITCH_ALLOC_STATS_EN
    logic [NUM_OUTPORTS-1:0] has_pending;

    always_comb begin
        has_pending = '0;
        for (int o = 0; o < NUM_OUTPORTS; o++) begin
            for (int b = 0; b < NUM_BUFFERS; b++) begin
                if (pending[b] && pend_port[b] == REQUEST_SIZE'(o))
                    has_pending[o] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            contention_cnt <= '0;
        end else begin
            for (int o = 0; o < NUM_OUTPORTS; o++) begin
                if (has_pending[o] && !port_win[o] && contention_cnt[o] != 16'hFFFF)
                    contention_cnt[o] <= contention_cnt[o] + 16'd1;
            end
        end
    end
`else
`endif

endmodule

// File: tb/tb_switch_allocator.sv
// tb/tb_switch_allocator.sv - directed and randomized checks of switch_allocator against a queue-level model
module tb_switch_allocator;

    localparam int NB = 4;
    localparam int NO = 4;

    logic            clk;
    logic            rst;
    logic [NB-1:0]   valid;
    logic            allocate;
    logic [1:0]      requestor;
    logic [1:0]      requested;
    logic [1:0]      switch_valid;
    logic [NO-1:0][1:0] select;
    logic [NO-1:0]   enable;
    logic [NB-1:0]   grant;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_on  = 0;

    // Model state: owner/enable per port, single queued entry per buffer.
    int m_en   [NO];
    int m_sel  [NO];
    int m_rr   [NO];
    int m_pend [NB];
    int m_pp   [NB];
    int m_grant[NB];
    int m_sv;

    switch_allocator #(.NUM_BUFFERS(NB), .NUM_OUTPORTS(NO)) dut (
        .clk(clk), .rst(rst), .valid(valid), .allocate(allocate),
        .requestor(requestor), .requested(requested),
        .switch_valid(switch_valid), .select(select), .enable(enable), .grant(grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    endtask

    function automatic int vec_en();
        int v = 0;
        for (int o = 0; o < NO; o++) if (m_en[o] != 0) v |= (1 << o);
        return v;
    endfunction

    function automatic int vec_grant();
        int v = 0;
        for (int b = 0; b < NB; b++) if (m_grant[b] != 0) v |= (1 << b);
        return v;
    endfunction

    task automatic model_step();
        int nen[NO];
        int nsel[NO];
        int nrr[NO];
        int r;
        int p;
        bit live;
        bit fresh;
        bit over;
        int best;
        int bestd;
        int d;
        bit isc;
        if (rst) begin
            for (int o = 0; o < NO; o++) begin m_en[o] = 0; m_sel[o] = 0; m_rr[o] = 0; end
            for (int b = 0; b < NB; b++) begin m_pend[b] = 0; m_pp[b] = 0; m_grant[b] = 0; end
            m_sv = 0;
            return;
        end
        nen = m_en; nsel = m_sel; nrr = m_rr;
        r = int'(requestor);
        p = int'(requested);
        live  = allocate && valid[r] && (p < NO);
        fresh = live && (m_pend[r] == 0);
        over  = live && (m_pend[r] != 0);
        for (int b = 0; b < NB; b++) m_grant[b] = 0;
        for (int o = 0; o < NO; o++) begin
            if (m_en[o] != 0) begin
                if (!valid[m_sel[o]]) nen[o] = 0;
                continue;
            end
            best = -1; bestd = NB;
            for (int b = 0; b < NB; b++) begin
                isc = (m_pend[b] != 0 && valid[b] && m_pp[b] == o && !(over && b == r))
                   || (fresh && b == r && p == o);
                d = (b - m_rr[o] + NB) % NB;
                if (isc && d < bestd) begin best = b; bestd = d; end
            end
            if (best >= 0) begin
                nen[o] = 1; nsel[o] = best; nrr[o] = (best + 1) % NB;
                m_grant[best] = 1;
            end
        end
        for (int b = 0; b < NB; b++) begin
            if (m_grant[b] != 0 || !valid[b]) m_pend[b] = 0;
            else if (live && b == r) begin m_pend[b] = 1; m_pp[b] = p; end
        end
        m_sv = (fresh && m_grant[r] != 0) ? 1 : 0;
        m_en = nen; m_sel = nsel; m_rr = nrr;
    endtask

    always @(posedge clk) begin
        #1;
        if (chk_on) begin
            check("enable", int'(enable), vec_en());
            check("grant", int'(grant), vec_grant());
            check("switch_valid", int'(switch_valid), m_sv);
            for (int o = 0; o < NO; o++) check($sformatf("select%0d", o), int'(select[o]), m_sel[o]);
        end
    end

    task automatic cyc(input bit r, input logic [NB-1:0] v, input bit a, input int rq, input int rp);
        @(negedge clk);
        rst = r; valid = v; allocate = a;
        requestor = 2'(rq); requested = 2'(rp);
        model_step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; valid = '0; allocate = 1'b0; requestor = '0; requested = '0;
        cyc(1, 4'b0000, 0, 0, 0);
        chk_on = 1;
        cyc(1, 4'b0000, 0, 0, 0);
        check("reset_enable", int'(enable), 0);
        check("reset_grant", int'(grant), 0);
        check("reset_sv", int'(switch_valid), 0);

        // Immediate grant
        cyc(0, 4'b0001, 1, 0, 2);
        check("t1_enable", int'(enable), 4'b0100);
        check("t1_select2", int'(select[2]), 0);
        check("t1_sv", int'(switch_valid), 1);
        check("t1_grant", int'(grant), 4'b0001);

        // Queue behind owner, handover after release
        cyc(0, 4'b0011, 1, 1, 2);
        check("t2_sv", int'(switch_valid), 0);
        check("t2_grant_q", int'(grant), 0);
        cyc(0, 4'b0010, 0, 0, 0);
        check("t2_released", int'(enable), 0);
        cyc(0, 4'b0010, 0, 0, 0);
        check("t2_enable", int'(enable), 4'b0100);
        check("t2_select2", int'(select[2]), 1);
        check("t2_grant", int'(grant), 4'b0010);
        cyc(0, 4'b0000, 0, 0, 0);
        cyc(0, 4'b0000, 0, 0, 0);

        // Round-robin on port0 starting from rr_ptr=2
        cyc(0, 4'b0010, 1, 1, 0);
        check("t3_first", int'(grant), 4'b0010);
        cyc(0, 4'b1110, 1, 2, 0);
        cyc(0, 4'b1110, 1, 3, 0);
        cyc(0, 4'b1100, 0, 0, 0);
        cyc(0, 4'b1110, 1, 1, 0);
        check("t3_grant2", int'(grant), 4'b0100);
        check("t3_sel2", int'(select[0]), 2);
        check("t3_sv_lost", int'(switch_valid), 0);
        cyc(0, 4'b1010, 0, 0, 0);
        cyc(0, 4'b1010, 0, 0, 0);
        check("t3_grant3", int'(grant), 4'b1000);
        cyc(0, 4'b0010, 0, 0, 0);
        cyc(0, 4'b0010, 0, 0, 0);
        check("t3_grant1", int'(grant), 4'b0010);
        check("t3_sel1", int'(select[0]), 1);
        cyc(0, 4'b0000, 0, 0, 0);
        cyc(0, 4'b0000, 0, 0, 0);

        // Request to a port in its release cycle
        cyc(0, 4'b0001, 1, 0, 3);
        cyc(0, 4'b0010, 1, 1, 3);
        check("t4_sv", int'(switch_valid), 0);
        check("t4_enable_low", int'(enable), 0);
        cyc(0, 4'b0010, 0, 0, 0);
        check("t4_grant", int'(grant), 4'b0010);
        check("t4_enable", int'(enable), 4'b1000);
        check("t4_select3", int'(select[3]), 1);
        cyc(0, 4'b0000, 0, 0, 0);

        // Rejection and cancellation
        cyc(0, 4'b0000, 1, 2, 1);
        check("t5_reject_sv", int'(switch_valid), 0);
        check("t5_reject_en", int'(enable), 0);
        cyc(0, 4'b0001, 1, 0, 1);
        cyc(0, 4'b0101, 1, 2, 1);
        cyc(0, 4'b0001, 0, 0, 0);
        cyc(0, 4'b0000, 0, 0, 0);
        cyc(0, 4'b0100, 0, 0, 0);
        check("t5_cancel_grant", int'(grant), 0);
        check("t5_cancel_en", int'(enable), 0);

        // Reset mid-operation
        cyc(0, 4'b0011, 1, 0, 1);
        cyc(0, 4'b0011, 1, 1, 2);
        cyc(0, 4'b1111, 1, 2, 1);
        cyc(0, 4'b1111, 1, 3, 2);
        cyc(1, 4'b1111, 0, 0, 0);
        check("t6_enable", int'(enable), 0);
        check("t6_select", int'(select), 0);
        check("t6_grant", int'(grant), 0);
        cyc(0, 4'b1100, 0, 0, 0);
        check("t6_after_grant", int'(grant), 0);
        check("t6_after_en", int'(enable), 0);

        // Randomized traffic
        valid = 4'b1111;
        for (int i = 0; i < 3000; i++) begin
            logic [NB-1:0] v;
            v = valid;
            for (int b = 0; b < NB; b++) if ($urandom_range(7) == 0) v[b] = ~v[b];
            cyc(($urandom_range(199) == 0), v, ($urandom_range(1) == 1),
                int'($urandom_range(NB - 1)), int'($urandom_range(NO - 1)));
        end

        chk_on = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
